ripple_pipe: RTL

Parametrised, pipelined carry-ripple adder/subtractor. It replaces the flat combinational 4-bit ripple adder wherever operand width or clock rate makes a single ripple chain too slow. The WIDTH-bit operation is split into SLICE-bit ripple segments, one per pipeline stage, with the carry registered between stages. It accepts one operation per cycle under a valid/ready handshake with full-pipeline stall.

---
 rtl/ripple_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ripple_pipe.sv
// Pipelined carry-ripple adder/subtractor: WIDTH bits split into SLICE-bit ripple
// segments, one per stage, with carry and skewed operands/results registered between stages.
module ripple_pipe #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SLICE;

    function automatic logic [SLICE:0] ripple(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             c
    );
        logic [SLICE:0] r;
        logic           cy;
        r  = '0;
        cy = c;
        for (int i = 0; i < SLICE; i++) begin
            r[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        r[SLICE] = cy;
        return r;
    endfunction

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    // Subtraction is A + ~B + ~cin, so cin acts as a borrow-in.
    assign b_eff_s   = in1 ^ {WIDTH{sub}};
    assign cin_eff_s = cin ^ sub;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = (k + 1) * SLICE;
            localparam int AW = WIDTH - k * SLICE;

            logic [AW-1:0]  opa_s;
            logic [AW-1:0]  opb_s;
            logic           carry_in_s;
            logic           valid_in_s;
            logic [LO-1:0]  res_in_s;
            logic [SLICE:0] sum_s;
            logic           valid_r;
            logic           carry_r;
            logic [LO-1:0]  res_r;

            if (k == 0) begin : g_head
                assign opa_s      = in0;
                assign opb_s      = b_eff_s;
                assign carry_in_s = cin_eff_s;
                assign valid_in_s = in_valid;
                assign res_in_s   = sum_s[SLICE-1:0];
            end else begin : g_body
                assign opa_s      = g_stage[k-1].g_fwd.a_r;
                assign opb_s      = g_stage[k-1].g_fwd.b_r;
                assign carry_in_s = g_stage[k-1].carry_r;
                assign valid_in_s = g_stage[k-1].valid_r;
                assign res_in_s   = {sum_s[SLICE-1:0], g_stage[k-1].res_r};
            end

            assign sum_s = ripple(opa_s[SLICE-1:0], opb_s[SLICE-1:0], carry_in_s);

            // Stage valid, carry and accumulated low result bits; data only moves with a valid op.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    carry_r <= 1'b0;
                    res_r   <= '0;
                end else if (advance_s) begin
                    valid_r <= valid_in_s;
                    if (valid_in_s) begin
                        carry_r <= sum_s[SLICE];
                        res_r   <= res_in_s;
                    end
                end
            end

            if (k < STAGES - 1) begin : g_fwd
                logic [AW-SLICE-1:0] a_r;
                logic [AW-SLICE-1:0] b_r;

                // Skew registers carrying the not-yet-added operand bits forward.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_r <= '0;
                        b_r <= '0;
                    end else if (advance_s && valid_in_s) begin
                        a_r <= opa_s[AW-1:SLICE];
                        b_r <= opb_s[AW-1:SLICE];
                    end
                end
            end else begin : g_tail
                logic ovf_r;

                // Signed overflow: carry into MSB (a^b^sum at MSB) xor carry out of MSB.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ovf_r <= 1'b0;
                    end else if (advance_s && valid_in_s) begin
                        ovf_r <= opa_s[SLICE-1] ^ opb_s[SLICE-1] ^ sum_s[SLICE-1] ^ sum_s[SLICE];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].valid_r;
    assign out       = g_stage[STAGES-1].res_r;
    assign cout      = g_stage[STAGES-1].carry_r;
    assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;
    assign in_ready  = !(out_valid && !out_ready);
    assign advance_s = in_ready;

endmodule
